fetch_unit: RTL

Program-counter and next-address stage of the single-cycle processor, sitting directly downstream of the decode control unit. Consumes its branch and jump decode flags (`j`, `jal`, `jr`, `bne`, `blt`, `bex`) together with ALU compare results and register data. Each cycle it selects and registers the next instruction address for instruction memory, supplies PC+1 for `jal` link writes, and holds the PC while a multi-cycle operation stalls the pipeline. Also keeps a retired-instruction counter.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_if.sv | 44 ++++
 rtl/pc_next_mux.sv | 67 ++++++
 rtl/fetch_unit.sv | 93 +++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch/next-PC stage.
// Imported by the interface, the next-PC mux and the top.
package fetch_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int CNT_W_DEF  = 32;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HOLD
    } state_e;

    typedef enum logic [1:0] {
        SEQ,
        BR,
        TGT,
        REG
    } src_e;

endpackage

// File: rtl/fetch_if.sv
// Decode-to-fetch bundle: control flags and operands in,
// instruction address and status out.
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic              j;
    logic              jal;
    logic              jr;
    logic              bne;
    logic              blt;
    logic              bex;
    logic              alu_ne;
    logic              alu_lt;
    logic              rstatus_nz;
    logic [26:0]       target;
    logic [16:0]       imm;
    logic [31:0]       rd_data;
    logic              stall;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus1;
    logic              fetch_valid;
    logic              redirect;
    logic [CNT_W-1:0]  retired;

    modport master (
        output j, jal, jr, bne, blt, bex,
        output alu_ne, alu_lt, rstatus_nz,
        output target, imm, rd_data, stall,
        input  pc, pc_plus1, fetch_valid,
        input  redirect, retired
    );

    modport slave (
        input  j, jal, jr, bne, blt, bex,
        input  alu_ne, alu_lt, rstatus_nz,
        input  target, imm, rd_data, stall,
        output pc, pc_plus1, fetch_valid,
        output redirect, retired
    );

endinterface

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection: priority pick among
// register, target, branch and sequential sources.
module pc_next_mux
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              j,
    input  logic              jal,
    input  logic              jr,
    input  logic              bne,
    input  logic              blt,
    input  logic              bex,
    input  logic              alu_ne,
    input  logic              alu_lt,
    input  logic              rstatus_nz,
    input  logic [ADDR_W-1:0] pc_plus1,
    input  logic [26:0]       target,
    input  logic [16:0]       imm,
    input  logic [31:0]       rd_data,
    output logic [ADDR_W-1:0] next_pc,
    output logic              nonseq
);

    src_e              src;
    logic [47:0]       imm_w;
    logic [ADDR_W:0]   imm_x;
    logic [ADDR_W:0]   br_sum;
    logic              unused_bits;

    assign imm_w  = {{31{imm[16]}}, imm};
    assign imm_x  = imm_w[ADDR_W:0];
    assign br_sum = {1'b0, pc_plus1} + imm_x;

    // Overlapping flags resolve by this priority order.
    always_comb begin
        src = SEQ;
        if (jr)
            src = REG;
        else if (j || jal)
            src = TGT;
        else if (bex && rstatus_nz)
            src = TGT;
        else if (bne && alu_ne)
            src = BR;
        else if (blt && alu_lt)
            src = BR;
    end

    always_comb begin
        next_pc = pc_plus1;
        unique case (src)
            REG:     next_pc = rd_data[ADDR_W-1:0];
            TGT:     next_pc = target[ADDR_W-1:0];
            BR:      next_pc = br_sum[ADDR_W-1:0];
            default: next_pc = pc_plus1;
        endcase
    end

    assign nonseq = (src != SEQ);

    assign unused_bits = ^{target[26:ADDR_W],
                           rd_data[31:ADDR_W],
                           imm_w[47:ADDR_W+1],
                           br_sum[ADDR_W]};

endmodule

// File: rtl/fetch_unit.sv
// PC register, BOOT/RUN/HOLD sequencing, redirect flag
// and retired-instruction counter.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input logic   clock,
    input logic   reset,
    fetch_if.slave bus
);

    state_e            state;
    state_e            state_nxt;
    logic              upd;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_p1;
    logic [ADDR_W-1:0] next_pc;
    logic              nonseq;
    logic              redirect_q;
    logic [CNT_W-1:0]  retired_q;

    assign pc_p1 = pc_q + ADDR_W'(1);

    pc_next_mux #(
        .ADDR_W (ADDR_W)
    ) u_mux (
        .j          (bus.j),
        .jal        (bus.jal),
        .jr         (bus.jr),
        .bne        (bus.bne),
        .blt        (bus.blt),
        .bex        (bus.bex),
        .alu_ne     (bus.alu_ne),
        .alu_lt     (bus.alu_lt),
        .rstatus_nz (bus.rstatus_nz),
        .pc_plus1   (pc_p1),
        .target     (bus.target),
        .imm        (bus.imm),
        .rd_data    (bus.rd_data),
        .next_pc    (next_pc),
        .nonseq     (nonseq)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= BOOT;
        else
            state <= state_nxt;
    end

    // BOOT spends one edge covering imem read latency.
    always_comb begin
        state_nxt = state;
        upd       = 1'b0;
        unique case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                if (bus.stall)
                    state_nxt = HOLD;
                else
                    upd = 1'b1;
            end
            HOLD: begin
                if (!bus.stall) begin
                    upd       = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q       <= '0;
            redirect_q <= 1'b0;
            retired_q  <= '0;
        end else if (upd) begin
            pc_q       <= next_pc;
            redirect_q <= nonseq;
            retired_q  <= retired_q + CNT_W'(1);
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus1    = pc_p1;
    assign bus.fetch_valid = (state != BOOT);
    assign bus.redirect    = redirect_q;
    assign bus.retired     = retired_q;

endmodule
